// File: rtl/img_cmd_ctrl.sv
// img_cmd_ctrl - UART command front-end for the remote-update image controller.
//
// Parses request frames  A5 CMD ARG CSUM  (CSUM = CMD ^ ARG) from the UART
// receiver. It issues single-cycle start_setimg / start_getimg strobes to the
// image controller. It then returns a response frame  5A CMD STATUS.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   rx_data, rx_valid      received byte + one-cycle strobe
//   tx_data, tx_valid      response byte, held until tx_ready
//   tx_ready               transmitter accepts when tx_valid & tx_ready
//   start_setimg           one-cycle strobe, setimg is the target image
//   start_getimg           one-cycle strobe, answered by done_getimg
//   setimg                 registered requested image
//   getimg, done_getimg    current image, valid while done_getimg is high
//   busy                   high in every state except IDLE
module img_cmd_ctrl #(
  parameter int parByteTimeout = 10000,
  parameter int parDoneTimeout = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       start_setimg,
  output logic       start_getimg,
  output logic [1:0] setimg,
  input  logic [1:0] getimg,
  input  logic       done_getimg,
  output logic       busy
);

  localparam logic [7:0] SOF_REQ = 8'hA5;
  localparam logic [7:0] SOF_RSP = 8'h5A;
  localparam logic [7:0] CMD_SET = 8'h01;
  localparam logic [7:0] CMD_GET = 8'h02;
  localparam logic [7:0] ST_BAD_CSUM = 8'hFF;
  localparam logic [7:0] ST_BAD_CMD  = 8'hFE;
  localparam logic [7:0] ST_BAD_ARG  = 8'hFD;
  localparam logic [7:0] ST_TIMEOUT  = 8'hFC;

  localparam int BW = $clog2(parByteTimeout + 1);
  localparam int DW = $clog2(parDoneTimeout + 1);

  typedef enum logic [3:0] {
    IDLE, CMD, ARG, CSUM, EXEC, WAIT_DONE, RESP0, RESP1, RESP2
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cmd_q, arg_q, status_q, status_n;
  logic [BW-1:0] byte_cnt;
  logic [DW-1:0] done_cnt;
  logic        byte_exp, done_exp, in_frame;
  logic        frame_err;
  logic [7:0]  err_code;

  assign in_frame = (state == CMD) || (state == ARG) || (state == CSUM);
  // Expiry fires on the cycle the idle count would reach the limit.
  assign byte_exp = (byte_cnt == BW'(parByteTimeout - 1));
  assign done_exp = (done_cnt == DW'(parDoneTimeout - 1));

  // Frame validation, evaluated against the CSUM byte currently on rx_data.
  // Priority: checksum, then command, then argument.
  always_comb begin
    frame_err = 1'b1;
    err_code  = 8'h00;
    if (rx_data != (cmd_q ^ arg_q))
      err_code = ST_BAD_CSUM;
    else if (cmd_q != CMD_SET && cmd_q != CMD_GET)
      err_code = ST_BAD_CMD;
    else if ((cmd_q == CMD_SET && arg_q[7:2] != 6'd0) ||
             (cmd_q == CMD_GET && arg_q != 8'h00))
      err_code = ST_BAD_ARG;
    else
      frame_err = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    status_n = status_q;
    case (state)
      IDLE:  if (rx_valid && rx_data == SOF_REQ) state_n = CMD;
      CMD:   if (rx_valid) state_n = ARG;  else if (byte_exp) state_n = IDLE;
      ARG:   if (rx_valid) state_n = CSUM; else if (byte_exp) state_n = IDLE;
      CSUM: begin
        if (rx_valid) begin
          if (frame_err) begin
            state_n  = RESP0;
            status_n = err_code;
          end else begin
            state_n = EXEC;
          end
        end else if (byte_exp) begin
          state_n = IDLE;
        end
      end
      EXEC: begin
        if (cmd_q == CMD_SET) begin
          state_n  = RESP0;
          status_n = 8'h00;
        end else begin
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_getimg) begin
          state_n  = RESP0;
          status_n = {6'd0, getimg};
        end else if (done_exp) begin
          state_n  = RESP0;
          status_n = ST_TIMEOUT;
        end
      end
      RESP0: if (tx_ready) state_n = RESP1;
      RESP1: if (tx_ready) state_n = RESP2;
      RESP2: if (tx_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register: no extra cycle of delay and no combinational outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q        <= 8'h00;
      arg_q        <= 8'h00;
      status_q     <= 8'h00;
      byte_cnt     <= '0;
      done_cnt     <= '0;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      start_setimg <= 1'b0;
      start_getimg <= 1'b0;
      setimg       <= 2'b00;
      busy         <= 1'b0;
    end else begin
      status_q <= status_n;
      if (state == CMD && rx_valid) cmd_q <= rx_data;
      if (state == ARG && rx_valid) arg_q <= rx_data;

      if (in_frame && !rx_valid && !byte_exp) byte_cnt <= byte_cnt + BW'(1);
      else                                   byte_cnt <= '0;

      if (state == WAIT_DONE && !done_getimg && !done_exp) done_cnt <= done_cnt + DW'(1);
      else                                                 done_cnt <= '0;

      // EXEC is held for exactly one cycle, so the strobes are one cycle wide.
      start_setimg <= (state_n == EXEC) && (cmd_q == CMD_SET);
      start_getimg <= (state_n == EXEC) && (cmd_q == CMD_GET);
      if (state_n == EXEC && cmd_q == CMD_SET) setimg <= arg_q[1:0];

      busy     <= (state_n != IDLE);
      tx_valid <= (state_n == RESP0) || (state_n == RESP1) || (state_n == RESP2);
      case (state_n)
        RESP0:   tx_data <= SOF_RSP;
        RESP1:   tx_data <= cmd_q;
        RESP2:   tx_data <= status_n;
        default: tx_data <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_img_cmd_ctrl.sv
module tb_img_cmd_ctrl;
  localparam int T = 20;  // byte timeout
  localparam int D = 50;  // done timeout

  logic       clk, reset;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_valid, tx_ready;
  logic       start_setimg, start_getimg, done_getimg, busy;
  logic [1:0] setimg, getimg;

  int checks = 0;
  int failures = 0;

  img_cmd_ctrl #(.parByteTimeout(T), .parDoneTimeout(D)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .start_setimg(start_setimg), .start_getimg(start_getimg),
    .setimg(setimg), .getimg(getimg), .done_getimg(done_getimg), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
    send_byte(8'hA5); send_byte(c); send_byte(a); send_byte(s);
  endtask

  // Expects tx_valid already high with the 5A byte, tx_ready high.
  task automatic resp3(input string tag, input logic [7:0] b1, input logic [7:0] b2);
    chk({tag, "_v0"}, tx_valid, 1);  chk({tag, "_b0"}, tx_data, 8'h5A); tick();
    chk({tag, "_v1"}, tx_valid, 1);  chk({tag, "_b1"}, tx_data, b1);    tick();
    chk({tag, "_v2"}, tx_valid, 1);  chk({tag, "_b2"}, tx_data, b2);    tick();
    chk({tag, "_end"}, tx_valid, 0); chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    getimg = 2'b00; done_getimg = 1'b0;
    tick(); tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_strobes", {start_setimg, start_getimg}, 2'b00);
    chk("rst_setimg", setimg, 2'b00);
    chk("rst_busy", busy, 0);
    reset = 1'b0; tick();

    // 1: SET image 3
    frame(8'h01, 8'h03, 8'h02);
    chk("set_strobe", start_setimg, 1);
    chk("set_getstrobe", start_getimg, 0);
    chk("set_setimg", setimg, 2'b11);
    chk("set_busy", busy, 1);
    tick();
    chk("set_strobe_off", start_setimg, 0);
    resp3("set", 8'h01, 8'h00);

    // 2: GET, done after 40 clocks with image 2
    frame(8'h02, 8'h00, 8'h02);
    chk("get_strobe", start_getimg, 1);
    chk("get_setstrobe", start_setimg, 0);
    for (int i = 0; i < 40; i++) tick();
    chk("get_wait_strobe", start_getimg, 0);
    chk("get_wait_txv", tx_valid, 0);
    done_getimg = 1'b1; getimg = 2'b10;
    tick();
    done_getimg = 1'b0; getimg = 2'b00;
    resp3("get", 8'h02, 8'h02);

    // 3: error frames
    frame(8'h01, 8'h02, 8'h07);
    chk("csum_strobe", {start_setimg, start_getimg}, 2'b00);
    resp3("csum", 8'h01, 8'hFF);
    chk("csum_setimg", setimg, 2'b11);
    frame(8'h07, 8'h00, 8'h07);
    chk("cmd_strobe", {start_setimg, start_getimg}, 2'b00);
    resp3("cmd", 8'h07, 8'hFE);
    frame(8'h01, 8'h04, 8'h05);
    chk("arg_strobe", {start_setimg, start_getimg}, 2'b00);
    resp3("arg", 8'h01, 8'hFD);
    chk("arg_setimg", setimg, 2'b11);

    // 4: byte timeout
    send_byte(8'hA5); send_byte(8'h01);
    for (int i = 0; i < T - 1; i++) tick();
    chk("to_before", busy, 1);
    tick();
    chk("to_expired", busy, 0);
    tick(); tick();
    chk("to_no_resp", tx_valid, 0);
    frame(8'h01, 8'h01, 8'h00);
    chk("to_set_strobe", start_setimg, 1);
    chk("to_setimg", setimg, 2'b01);
    tick();
    resp3("to_set", 8'h01, 8'h00);
    // ARG byte arrives on the exact expiry cycle and must be taken
    send_byte(8'hA5); send_byte(8'h01);
    for (int i = 0; i < T - 1; i++) tick();
    send_byte(8'h00);
    chk("exp_accept_busy", busy, 1);
    send_byte(8'h01);
    chk("exp_strobe", start_setimg, 1);
    chk("exp_setimg", setimg, 2'b00);
    tick();
    resp3("exp", 8'h01, 8'h00);

    // 5: done timeout, then backpressure in RESP1
    frame(8'h02, 8'h00, 8'h02);
    chk("dto_strobe", start_getimg, 1);
    for (int i = 0; i < D; i++) tick();
    chk("dto_not_yet", tx_valid, 0);
    tick();
    chk("dto_v0", tx_valid, 1);
    chk("dto_b0", tx_data, 8'h5A);
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {tx_valid, tx_data}, {1'b1, 8'h02});
      tick();
    end
    tx_ready = 1'b1;
    chk("bp_b1", tx_data, 8'h02);
    tick();
    chk("dto_b2", tx_data, 8'hFC);
    tick();
    chk("dto_end", tx_valid, 0);

    // 6: reset during WAIT_DONE, then stale done pulse
    frame(8'h02, 8'h00, 8'h02);
    tick(); tick(); tick();
    chk("rw_busy", busy, 1);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("rw_busy_rst", busy, 0);
    chk("rw_setimg", setimg, 2'b00);
    done_getimg = 1'b1; getimg = 2'b11;
    tick();
    done_getimg = 1'b0;
    tick(); tick();
    chk("rw_outs", {busy, tx_valid, tx_data, start_setimg, start_getimg}, 12'h000);

    // bytes during RESPx are discarded
    tx_ready = 1'b0;
    frame(8'h01, 8'h02, 8'h03);
    chk("rx_setimg", setimg, 2'b10);
    tick();
    chk("rx_resp0", tx_valid, 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    chk("rx_no_strobe", start_setimg, 0);
    tx_ready = 1'b1;
    resp3("rx", 8'h01, 8'h00);
    tick(); tick();
    chk("rx_dropped", {busy, tx_valid}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/img_cmd_ctrl.md
Name: img_cmd_ctrl

Overview:
- Command front-end for the remote-update image controller; sits directly upstream of ImageControl_v3.
- Decodes framed byte commands from the UART receiver and issues single-cycle start_setimg / start_getimg strobes plus the setimg target.
- Waits for done_getimg on reads, then returns a 3-byte response frame to the UART transmitter.

Parameters:
parByteTimeout, 10000, idle clocks between frame bytes before the parser drops the partial frame.
parDoneTimeout, 100000, clocks to wait for done_getimg before reporting failure.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
rx_data  in  8  received byte.
rx_valid  in  1  one-cycle strobe; rx_data valid.
tx_data  out  8  response byte.
tx_valid  out  1  response byte valid; held until accepted.
tx_ready  in  1  transmitter accepts tx_data when tx_valid & tx_ready.
start_setimg  out  1  one-cycle strobe to the image controller.
start_getimg  out  1  one-cycle strobe to the image controller.
setimg  out  2  requested image; registered.
getimg  in  2  current image from the image controller.
done_getimg  in  1  read complete; getimg valid in the same cycle.
busy  out  1  high in every state except IDLE.

Behaviour:
- Request frame: 0xA5, CMD, ARG, CSUM, where CSUM = CMD ^ ARG.
- Response frame: 0x5A, CMD (echoed), STATUS.
- Commands:
  - CMD 0x01 SET: ARG[7:2] must be 0. Sets setimg = ARG[1:0], pulses start_setimg, returns STATUS 0x00.
  - CMD 0x02 GET: ARG must be 0x00. Pulses start_getimg, waits for done_getimg, returns STATUS {6'b0, getimg}.
- Error STATUS codes: 0xFF bad CSUM; 0xFE unknown CMD; 0xFD bad ARG; 0xFC done_getimg timeout. On any error, no strobe is issued and setimg is unchanged.
- Error check priority: CSUM, then CMD, then ARG.
- FSM states: IDLE, CMD, ARG, CSUM, EXEC, WAIT_DONE, RESP0, RESP1, RESP2.
  - IDLE: a byte equal to 0xA5 moves to CMD; any other byte is discarded.
  - CMD -> ARG -> CSUM: each state captures one byte on rx_valid.
  - CSUM byte accepted in cycle N -> EXEC in N+1. The strobe for SET/GET is high only in N+1; error frames go straight to RESP0.
  - SET: EXEC -> RESP0, so tx_valid first rises in N+2.
  - GET: EXEC -> WAIT_DONE, and done_getimg is sampled from N+2. If done_getimg is high in cycle M, getimg is captured in M and tx_valid rises in M+1. If done_getimg is not seen within parDoneTimeout clocks, send STATUS 0xFC.
  - RESP0..RESP2 each present one byte with tx_valid high until tx_ready. Advance on acceptance; after RESP2 is accepted, return to IDLE in the next cycle.
- Byte timeout:
  - The counter is active only in CMD, ARG and CSUM. It resets on every rx_valid.
  - When it reaches parByteTimeout, the FSM returns to IDLE and no response is sent.
  - If rx_valid and expiry occur in the same cycle, the byte wins: it is accepted and the counter is cleared.
- rx_valid in EXEC, WAIT_DONE or RESPx: byte discarded, no queuing.
- 0xA5 inside a frame is treated as data; there is no resync except via timeout.
- Reset values: tx_data 0x00, tx_valid 0, start_setimg 0, start_getimg 0, setimg 2'b00, busy 0, FSM IDLE, counters 0.
- Reset asserted mid-frame or mid-wait:
  - The next cycle is IDLE with all outputs at reset values.
  - A pending done_getimg is ignored.
  - A strobe is never stretched.
- busy is registered and follows the state with no extra delay.

Test Plan:
1. Frame A5 01 03 02 -> start_setimg high exactly 1 cycle, 1 cycle after the CSUM byte; setimg = 2'b11; response 5A 01 00 with tx_ready tied high.
2. Frame A5 02 00 02; image controller returns done_getimg with getimg = 2'b10 after 40 clocks -> one start_getimg pulse; response 5A 02 02.
3. Frame A5 01 02 07 (bad CSUM) -> no strobe, setimg unchanged; response 5A 01 FF. Frame A5 07 00 07 -> 5A 07 FE. Frame A5 01 04 05 -> 5A 01 FD.
4. Send A5 01, then idle for parByteTimeout clocks -> FSM in IDLE, no response. Then a full valid SET frame -> completes normally. Also drive a byte on the exact expiry cycle -> byte accepted.
5. GET with done_getimg never asserted (parDoneTimeout set to 50) -> response 5A 02 FC after 50 clocks. Separately, hold tx_ready low 10 cycles during RESP1 -> tx_data stable at 0x02 and tx_valid held high.
6. Assert reset during WAIT_DONE, then pulse done_getimg -> FSM in IDLE, no response, all outputs at reset values. Bytes sent during RESPx -> discarded.
